// File: rtl/rf_writeback_arbiter_if.sv
// Purpose: bundles the execute/memory-side request lines and the register-file write port for the arbiter.
// Latency: none, this is wiring only.
// Backpressure: lsu_ready (load FIFO space) and alu_stall (ALU must idle) both flow back to the master.
//
// Ports (master = pipeline side, slave = arbiter):
//   alu_we/alu_rd/alu_wd       ALU result, no backpressure except alu_stall
//   lsu_valid/lsu_ready/lsu_rd/lsu_wd  load result handshake
//   WE3/A3/WD3                 registered register-file write port
//   chk_a1/chk_a2 -> pend_a1/pend_a2   pending-write lookup for RAW stalls
//   fifo_count, alu_stall, proto_err   status
interface rf_writeback_arbiter_if #(
    parameter int DEPTH = 4
);
    logic                     alu_we;
    logic [4:0]               alu_rd;
    logic [31:0]              alu_wd;
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [4:0]               lsu_rd;
    logic [31:0]              lsu_wd;
    logic                     alu_stall;
    logic                     WE3;
    logic [4:0]               A3;
    logic [31:0]              WD3;
    logic [4:0]               chk_a1;
    logic [4:0]               chk_a2;
    logic                     pend_a1;
    logic                     pend_a2;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     proto_err;

    modport master (
        output alu_we, alu_rd, alu_wd,
        output lsu_valid, lsu_rd, lsu_wd,
        output chk_a1, chk_a2,
        input  lsu_ready, alu_stall,
        input  WE3, A3, WD3,
        input  pend_a1, pend_a2,
        input  fifo_count, proto_err
    );

    modport slave (
        input  alu_we, alu_rd, alu_wd,
        input  lsu_valid, lsu_rd, lsu_wd,
        input  chk_a1, chk_a2,
        output lsu_ready, alu_stall,
        output WE3, A3, WD3,
        output pend_a1, pend_a2,
        output fifo_count, proto_err
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Purpose: single writer for the register-file write port; merges ALU results and FIFO-queued load results.
// Latency: ALU -> WE3 one edge; accepted load -> WE3 no earlier than two edges after acceptance.
// Backpressure: lsu_ready low when the load FIFO is full; alu_stall asks the ALU to idle after
//               STARVE_LIMIT consecutive wins over a waiting load.
//
// Ports: clk, rst (async, active-high), bus (rf_writeback_arbiter_if.slave, see interface file).
// DEPTH must match the interface DEPTH; it must be a power of two >= 2. STARVE_LIMIT >= 1.
module rf_writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Load FIFO storage; validity comes from r_rd_ptr/r_count, so no per-entry valid bits.
    logic [4:0]    r_fifo_rd [DEPTH];
    logic [31:0]   r_fifo_wd [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_we3;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;
    logic          r_proto_err;

    logic          w_empty;
    logic          w_full;
    logic          w_lsu_ready;
    logic          w_push;
    logic          w_alu_req;
    logic          w_stall;
    logic          w_alu_win;
    logic          w_pop;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_wd;
    logic [DEPTH-1:0] w_ent_vld;
    logic          w_pend_a1;
    logic          w_pend_a2;

    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == FULL_CNT);
        w_lsu_ready = !rst && !w_full;
        // x0 loads complete the handshake but never occupy a slot.
        w_push      = bus.lsu_valid && w_lsu_ready && (bus.lsu_rd != 5'd0);
        w_alu_req   = bus.alu_we && (bus.alu_rd != 5'd0);
        w_stall     = (r_starve == STARVE_MAX);
        // A stalled ALU request is dropped outright, so the ALU can only win while not stalled.
        w_alu_win   = w_alu_req && !w_stall;
        // Head pops whenever the ALU does not take the port (covers the forced pop during stall).
        w_pop       = !w_empty && !w_alu_win;
        w_head_rd   = r_fifo_rd[r_rd_ptr];
        w_head_wd   = r_fifo_wd[r_rd_ptr];
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        w_ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_vld[i] = ({1'b0, AW'(i) - r_rd_ptr} < r_count);
        end
    end

    // The output register is included because the register file has no write-through.
    always_comb begin
        w_pend_a1 = r_we3 && (r_a3 == bus.chk_a1);
        w_pend_a2 = r_we3 && (r_a3 == bus.chk_a2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i] && (r_fifo_rd[i] == bus.chk_a1)) w_pend_a1 = 1'b1;
            if (w_ent_vld[i] && (r_fifo_rd[i] == bus.chk_a2)) w_pend_a2 = 1'b1;
        end
        if (bus.chk_a1 == 5'd0) w_pend_a1 = 1'b0;
        if (bus.chk_a2 == 5'd0) w_pend_a2 = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_we3       <= 1'b0;
            r_a3        <= 5'd0;
            r_wd3       <= 32'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            // Starvation only accumulates while a load is actually waiting.
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (w_alu_win && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end

            if (w_pop) begin
                r_we3 <= 1'b1;
                r_a3  <= w_head_rd;
                r_wd3 <= w_head_wd;
            end else if (w_alu_win) begin
                r_we3 <= 1'b1;
                r_a3  <= bus.alu_rd;
                r_wd3 <= bus.alu_wd;
            end else begin
                r_we3 <= 1'b0;
            end

            if (w_alu_req && w_stall) r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr] <= bus.lsu_rd;
            r_fifo_wd[r_wr_ptr] <= bus.lsu_wd;
        end
    end

    assign bus.lsu_ready  = w_lsu_ready;
    assign bus.alu_stall  = w_stall;
    assign bus.WE3        = r_we3;
    assign bus.A3         = r_a3;
    assign bus.WD3        = r_wd3;
    assign bus.pend_a1    = w_pend_a1;
    assign bus.pend_a2    = w_pend_a2;
    assign bus.fifo_count = r_count;
    assign bus.proto_err  = r_proto_err;
endmodule
